lfsr_range_sampler: RTL and testbench
=====================================

Name: lfsr_range_sampler

Overview:
Consumes the 64-bit `shift_seed` word produced each cycle by `lfsr`. It turns that word into uniformly distributed integers in [0, limit) by rejection sampling. Accepted samples are buffered in a small FWFT FIFO and handed to the consumer (game/board logic) over a valid/ready handshake. It also detects a stuck LFSR (all-zero state) and runaway rejection.

Parameters:
OUT_W, 6, sample width in bits; candidate = lfsr_in[OUT_W-1:0]
DEPTH, 4, FIFO depth in entries (power of 2, >=2)
REJ_MAX, 16, consecutive rejections that trigger ERROR

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
lfsr_in  input  64  LFSR output word, new value every cycle
limit  input  OUT_W  exclusive upper bound; latched on start
start  input  1  one-cycle pulse; IDLE -> RUN
stop  input  1  one-cycle pulse; RUN -> IDLE
clear  input  1  one-cycle pulse; ERROR -> IDLE, flushes FIFO
out_data  output  OUT_W  FIFO head sample
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head when high with out_valid
busy  output  1  state == RUN
err  output  1  state == ERROR
err_code  output  2  0 none, 1 limit zero, 2 LFSR all-zero, 3 reject overflow

Behaviour:
- Reset: reset sampled low at posedge clears all state.
  - state=IDLE; FIFO empty; out_valid=0; out_data=0.
  - busy=0; err=0; err_code=0; limit_q=0; rej_cnt=0.
- States are IDLE, RUN and ERROR. All transitions are registered.
- IDLE, start=1:
  - limit==0 -> ERROR, err_code=1.
  - otherwise latch limit_q=limit, rej_cnt=0, go to RUN.
- IDLE ignores stop and clear.
- RUN, each cycle, in priority order:
  - stop=1 -> IDLE. No sample is taken that cycle. FIFO contents are retained and stay drainable.
  - lfsr_in==0 -> ERROR, err_code=2. No push.
  - cand = lfsr_in[OUT_W-1:0]. If cand < limit_q (unsigned):
    - If FIFO has space, push cand and set rej_cnt=0.
    - "Has space" means count<DEPTH, or count==DEPTH with a pop in the same cycle.
    - If FIFO is full with no pop, drop cand. rej_cnt is unchanged (a full FIFO is not a rejection).
  - If cand >= limit_q: rej_cnt+1. When rej_cnt reaches REJ_MAX -> ERROR, err_code=3.
- start in RUN is ignored; limit is not re-latched.
- ERROR:
  - Pushes are blocked.
  - Pops continue, so the consumer may drain existing entries.
  - clear=1 -> IDLE, FIFO flushed, err_code=0.
  - start and stop are ignored.
- FIFO is first-word-fall-through.
  - out_data = head entry; out_valid = (count != 0).
  - Pop happens when out_valid && out_ready.
  - Simultaneous push and pop keeps count unchanged.
  - Pointers wrap modulo DEPTH.
  - out_data holds its last value when empty; out_valid=0.
- Latency: a candidate accepted at posedge N appears on out_data/out_valid after posedge N (visible in cycle N+1) if the FIFO was empty.
- Throughput: at most 1 sample per cycle.
- Reset mid-operation: takes precedence over everything. FIFO contents are discarded.

Optional Feature:
Macro: `LFSR_SAMPLER_STATS_EN`.
- Defined: adds outputs acc_cnt[15:0] and rej_total[15:0].
  - acc_cnt counts pushes; rej_total counts rejections.
  - Both saturate at 16'hFFFF.
  - Both are cleared by reset and by start in IDLE; they hold in ERROR.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset, then start with limit=40. Drive lfsr_in low bits 5, 39, 40, 63, 12, out_ready=1 -> accepted 5, 39, 12 in order. rej_cnt peaks at 2 and returns to 0 on 12. busy=1.
- out_ready=0, limit=40, lfsr_in low bits 1,2,3,4,5,6 -> FIFO holds 1,2,3,4; 5 and 6 dropped; err=0.
  - Then out_ready=1 -> pops 1,2,3,4 in 4 cycles with pushes continuing.
- start with limit=0 -> err=1, err_code=1 after one cycle.
  - clear -> IDLE, err=0, err_code=0.
- In RUN with limit=40, drive lfsr_in=64'h0 -> err_code=2. Next-cycle pushes are blocked; existing FIFO entries still drain.
- limit=1, lfsr_in low bits=63 for 16 consecutive cycles -> err_code=3 on the 16th.
  - Same with an accepted 0 at cycle 15 -> no error, rej_cnt restarts.
- In RUN with 2 entries queued, assert stop and a reset pulse in separate runs:
  - stop -> IDLE, 2 entries still poppable.
  - reset -> out_valid=0, state IDLE immediately after the edge.

Source files
------------

// File: rtl/lfsr_range_sampler.sv
// Rejection sampler: turns LFSR words into uniform integers in [0, limit), buffered in an FWFT FIFO.
// Optional acceptance/rejection statistics outputs are enabled by defining LFSR_SAMPLER_STATS_EN.
module lfsr_range_sampler #(
  parameter int OUT_W   = 6,
  parameter int DEPTH   = 4,
  parameter int REJ_MAX = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      lfsr_in,
  input  logic [OUT_W-1:0] limit,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             err,
  output logic [1:0]       err_code
`ifdef LFSR_SAMPLER_STATS_EN
  ,
  output logic [15:0]      acc_cnt,
  output logic [15:0]      rej_total
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int REJ_W = $clog2(REJ_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ERROR} state_t;
  typedef enum logic [1:0] {E_NONE, E_LIMIT_ZERO, E_LFSR_ZERO, E_REJ_OVF} err_t;

  state_t             state, state_nx;
  err_t               err_q, err_nx;
  logic [OUT_W-1:0]   limit_q;
  logic [REJ_W-1:0]   rej_cnt, rej_nx;
  logic [OUT_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr, rd_nx;
  logic [CNT_W-1:0]   count, cnt_nx;
  logic [OUT_W-1:0]   cand, head_nx;
  logic               in_range, pop, space, push, reject, flush, arm;

  assign out_valid = (count != '0);
  assign err_code  = err_q;

  // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    cand     = lfsr_in[OUT_W-1:0];
    in_range = (cand < limit_q);
    pop      = out_valid && out_ready;
    space    = (count < CNT_W'(DEPTH)) || pop;
    state_nx = state;
    err_nx   = err_q;
    rej_nx   = rej_cnt;
    push     = 1'b0;
    reject   = 1'b0;
    flush    = 1'b0;
    arm      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          arm = 1'b1;
          if (limit == '0) begin
            state_nx = S_ERROR;
            err_nx   = E_LIMIT_ZERO;
          end else begin
            state_nx = S_RUN;
            rej_nx   = '0;
          end
        end
      end
      S_RUN: begin
        if (stop) begin
          state_nx = S_IDLE;
        end else if (lfsr_in == 64'd0) begin
          state_nx = S_ERROR;
          err_nx   = E_LFSR_ZERO;
        end else if (in_range) begin
          // A full FIFO drops the candidate without counting it as a rejection.
          if (space) begin
            push   = 1'b1;
            rej_nx = '0;
          end
        end else begin
          reject = 1'b1;
          rej_nx = rej_cnt + REJ_W'(1);
          if (rej_nx == REJ_W'(REJ_MAX)) begin
            state_nx = S_ERROR;
            err_nx   = E_REJ_OVF;
          end
        end
      end
      S_ERROR: begin
        if (clear) begin
          state_nx = S_IDLE;
          err_nx   = E_NONE;
          flush    = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    rd_nx  = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    cnt_nx = count + CNT_W'(push) - CNT_W'(pop);
    // The new head is being written this cycle when it lands on the write slot.
    if (cnt_nx == '0)                   head_nx = out_data;
    else if (push && (rd_nx == wr_ptr)) head_nx = cand;
    else                                head_nx = mem[rd_nx];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      err_q    <= E_NONE;
      busy     <= 1'b0;
      err      <= 1'b0;
      limit_q  <= '0;
      rej_cnt  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_data <= '0;
    end else begin
      state   <= state_nx;
      err_q   <= err_nx;
      busy    <= (state_nx == S_RUN);
      err     <= (state_nx == S_ERROR);
      rej_cnt <= rej_nx;
      if (arm && (limit != '0)) limit_q <= limit;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        rd_ptr   <= rd_nx;
        count    <= cnt_nx;
        out_data <= head_nx;
      end
    end
  end

  // NOTE: storage is not reset; occupancy is tracked by count and the visible head is its own register.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cand;
  end

`ifdef LFSR_SAMPLER_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset || arm) begin
      acc_cnt   <= '0;
      rej_total <= '0;
    end else begin
      if (push && (acc_cnt != 16'hFFFF))     acc_cnt   <= acc_cnt + 16'd1;
      if (reject && (rej_total != 16'hFFFF)) rej_total <= rej_total + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_range_sampler.sv
// Directed, table-driven bench for lfsr_range_sampler with hand-written rejection-overflow sequences.
module tb_lfsr_range_sampler;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] lfsr_in;
  logic [5:0]  limit;
  logic        start, stop, clear, out_ready;
  logic [5:0]  out_data;
  logic        out_valid, busy, err;
  logic [1:0]  err_code;
`ifdef LFSR_SAMPLER_STATS_EN
  logic [15:0] acc_cnt, rej_total;
`endif

  int passed = 0;
  int total  = 0;

  lfsr_range_sampler #(.OUT_W(6), .DEPTH(4), .REJ_MAX(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .lfsr_in   (lfsr_in),
    .limit     (limit),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .err       (err),
    .err_code  (err_code)
`ifdef LFSR_SAMPLER_STATS_EN
    ,
    .acc_cnt   (acc_cnt),
    .rej_total (rej_total)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst_n, st, sp, cl;
    logic [5:0] lim;
    int         lv;      // candidate low bits; negative means an all-zero LFSR word
    bit         rdy;
    bit         e_valid;
    logic [5:0] e_data;
    bit         e_busy, e_err;
    logic [1:0] e_code;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] mk(input int lv);
    if (lv < 0) return 64'h0;
    return {32'hDEAD_BEEF, 26'h0, lv[5:0]};
  endfunction

  function automatic vec_t v(input bit rst_n, st, sp, cl, input int lim, lv, input bit rdy,
                             input bit ev, input int ed, input bit eb, ee, input int ec);
    vec_t r;
    r.rst_n = rst_n; r.st = st; r.sp = sp; r.cl = cl; r.lim = lim[5:0]; r.lv = lv; r.rdy = rdy;
    r.e_valid = ev; r.e_data = ed[5:0]; r.e_busy = eb; r.e_err = ee; r.e_code = ec[1:0];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit st, sp, cl, input int lim, lv, input bit rdy);
    start = st; stop = sp; clear = cl; limit = lim[5:0]; lfsr_in = mk(lv); out_ready = rdy;
  endtask

  task automatic check_status(input string tag, input bit eb, ee, input int ec);
    check({tag, " busy"}, 32'(busy), 32'(eb));
    check({tag, " err"}, 32'(err), 32'(ee));
    check({tag, " err_code"}, 32'(err_code), 32'(ec));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //                rst st sp cl lim  lv rdy | val data busy err code
    vecs.push_back(v(1, 1, 0, 0, 40,  1, 1,  0,  0, 1, 0, 0)); // start, limit 40
    vecs.push_back(v(1, 0, 0, 0, 40,  5, 1,  1,  5, 1, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 40, 39, 1,  1, 39, 1, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 40, 40, 1,  0, 39, 1, 0, 0)); // reject
    vecs.push_back(v(1, 0, 0, 0, 40, 63, 1,  0, 39, 1, 0, 0)); // reject
    vecs.push_back(v(1, 0, 0, 0, 40, 12, 1,  1, 12, 1, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 40, 40, 1,  0, 12, 1, 0, 0)); // drain
    vecs.push_back(v(1, 0, 0, 0, 40,  1, 0,  1,  1, 1, 0, 0)); // fill with ready low
    vecs.push_back(v(1, 0, 0, 0, 40,  2, 0,  1,  1, 1, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 40,  3, 0,  1,  1, 1, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 40,  4, 0,  1,  1, 1, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 40,  5, 0,  1,  1, 1, 0, 0)); // full: dropped
    vecs.push_back(v(1, 0, 0, 0, 40,  6, 0,  1,  1, 1, 0, 0)); // full: dropped
    vecs.push_back(v(1, 0, 0, 0, 40,  7, 1,  1,  2, 1, 0, 0)); // push+pop while full
    vecs.push_back(v(1, 0, 0, 0, 40,  8, 1,  1,  3, 1, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 40,  9, 1,  1,  4, 1, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 40, 10, 1,  1,  7, 1, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 40, -1, 1,  1,  8, 0, 1, 2)); // all-zero LFSR
    vecs.push_back(v(1, 0, 0, 0, 40,  5, 1,  1,  9, 0, 1, 2)); // push blocked, pop continues
    vecs.push_back(v(1, 1, 1, 0, 40,  5, 0,  1,  9, 0, 1, 2)); // start/stop ignored in ERROR
    vecs.push_back(v(1, 0, 0, 1, 40,  5, 0,  0,  9, 0, 0, 0)); // clear flushes
    vecs.push_back(v(1, 1, 0, 0,  0,  5, 0,  0,  9, 0, 1, 1)); // start with limit 0
    vecs.push_back(v(1, 0, 0, 1,  0,  5, 0,  0,  9, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 0, 40,  5, 0,  0,  9, 1, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 40, 20, 0,  1, 20, 1, 0, 0));
    vecs.push_back(v(1, 1, 0, 0, 10, 21, 0,  1, 20, 1, 0, 0)); // start in RUN: limit kept at 40
    vecs.push_back(v(1, 0, 1, 0, 40, 22, 0,  1, 20, 0, 0, 0)); // stop: no sample, FIFO kept
    vecs.push_back(v(1, 0, 0, 0, 40, 23, 1,  1, 21, 0, 0, 0)); // drain in IDLE
    vecs.push_back(v(1, 0, 0, 0, 40, 24, 1,  0, 21, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 0, 40,  1, 0,  0, 21, 1, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 40, 30, 0,  1, 30, 1, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 40, 31, 0,  1, 30, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 40, 32, 0,  0,  0, 0, 0, 0)); // reset mid-run
    vecs.push_back(v(1, 1, 0, 0,  1, 63, 0,  0,  0, 1, 0, 0)); // start, limit 1

    reset = 1'b0;
    drive(0, 0, 0, 0, 1, 0);
    step();
    step();
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check_status("reset", 0, 0, 0);

    foreach (vecs[i]) begin
      string tag;
      tag   = $sformatf("row%0d", i);
      reset = vecs[i].rst_n;
      drive(vecs[i].st, vecs[i].sp, vecs[i].cl, vecs[i].lim, vecs[i].lv, vecs[i].rdy);
      step();
      check({tag, " out_valid"}, 32'(out_valid), 32'(vecs[i].e_valid));
      check({tag, " out_data"}, 32'(out_data), 32'(vecs[i].e_data));
      check_status(tag, vecs[i].e_busy, vecs[i].e_err, vecs[i].e_code);
    end

    // Sixteen consecutive rejections with limit 1 raise the overflow error on the last one.
    for (int i = 1; i <= 16; i++) begin
      drive(0, 0, 0, 1, 63, 1);
      step();
      check_status($sformatf("rej%0d", i), i < 16, i == 16, (i == 16) ? 3 : 0);
    end
    drive(0, 0, 1, 1, 63, 1);
    step();
    check_status("clear after overflow", 0, 0, 0);
    drive(1, 0, 0, 1, 63, 1);
    step();
    check_status("restart", 1, 0, 0);

    // An accepted sample on the 15th cycle resets the consecutive-rejection count.
    for (int i = 1; i <= 14; i++) begin
      drive(0, 0, 0, 1, 63, 1);
      step();
    end
    check_status("after 14 rejects", 1, 0, 0);
    drive(0, 0, 0, 1, 0, 1);
    step();
    check("accept0 out_valid", 32'(out_valid), 32'd1);
    check("accept0 out_data", 32'(out_data), 32'd0);
    check_status("accept0", 1, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      drive(0, 0, 0, 1, 63, 1);
      step();
      if (i == 1) check("drain after accept", 32'(out_valid), 32'd0);
      check_status($sformatf("rerej%0d", i), i < 16, i == 16, (i == 16) ? 3 : 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
